// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Op codes, slice result-select values, issue control struct and
//            the op -> slice-control decode for the ALU issue stage.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  // Control half of an issue entry; the operands are prepended by the stage.
  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] sel;
    logic       cin;
    logic       illegal;
  } issue_ctrl_t;

  localparam int CTRL_W = $bits(issue_ctrl_t);

  function automatic issue_ctrl_t alu_decode(input logic [3:0] op);
    issue_ctrl_t c;
    c = '0;
    case (op)
      OP_AND:  c.sel = SEL_AND;
      OP_OR:   c.sel = SEL_OR;
      OP_ADD:  c.sel = SEL_SUM;
      OP_SUB:  begin c.binv = 1'b1; c.sel = SEL_SUM;  c.cin = 1'b1; end
      OP_SLT:  begin c.binv = 1'b1; c.sel = SEL_LESS; c.cin = 1'b1; end
      OP_NOR:  begin c.ainv = 1'b1; c.binv = 1'b1; c.sel = SEL_AND; end
      OP_NAND: begin c.ainv = 1'b1; c.binv = 1'b1; c.sel = SEL_OR;  end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_skid_buffer
// Purpose  : Two-entry (main + skid) registered valid/ready buffer; main
//            drives the output, ready is a pure register.
// Revision : 1.0  initial release
// ============================================================================
module alu_skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;

  logic w_accept;
  logic w_drain;
  logic w_main_free;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;
  logic w_main_load_in;
  logic w_main_load_skid;
  logic w_skid_load;

  assign w_accept    = i_valid & r_in_ready;
  assign w_drain     = r_main_valid & i_ready;
  assign w_main_free = ~r_main_valid | w_drain;

  // Ready is registered, so no accept can arrive while the skid is occupied.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_load_in   = 1'b0;
    w_main_load_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (r_skid_valid) begin
      if (w_drain) begin
        w_main_load_skid = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      if (w_main_free) begin
        w_main_load_in   = 1'b1;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_skid_load      = 1'b1;
        w_skid_valid_nxt = 1'b1;
      end
    end else if (w_drain) begin
      w_main_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      if (w_main_load_in) begin
        r_main_data <= i_data;
      end else if (w_main_load_skid) begin
        r_main_data <= r_skid_data;
      end
      if (w_skid_load) begin
        r_skid_data <= i_data;
      end
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Decodes ALU ops into slice controls and issues them, with
//            operands, through a two-entry skid buffer.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_ainv,
  output logic             out_binv,
  output logic [1:0]       out_sel,
  output logic             out_cin,
  output logic             out_illegal
);

  localparam int ENTRY_W = 2 * WIDTH + CTRL_W;

  issue_ctrl_t        w_ctrl_in;
  issue_ctrl_t        w_ctrl_out;
  logic [ENTRY_W-1:0] w_entry_in;
  logic [ENTRY_W-1:0] w_entry_out;

  // Entry layout, MSB first: {a, b, ctrl}.
  assign w_ctrl_in  = alu_decode(in_op);
  assign w_entry_in = {in_a, in_b, w_ctrl_in};

  alu_skid_buffer #(
    .DATA_W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_entry_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_entry_out)
  );

  assign out_a       = w_entry_out[ENTRY_W-1 -: WIDTH];
  assign out_b       = w_entry_out[CTRL_W +: WIDTH];
  assign w_ctrl_out  = w_entry_out[CTRL_W-1:0];
  assign out_ainv    = w_ctrl_out.ainv;
  assign out_binv    = w_ctrl_out.binv;
  assign out_sel     = w_ctrl_out.sel;
  assign out_cin     = w_ctrl_out.cin;
  assign out_illegal = w_ctrl_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Self-checking bench for alu_issue_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic        out_ainv;
  logic        out_binv;
  logic [1:0]  out_sel;
  logic        out_cin;
  logic        out_illegal;

  int checks   = 0;
  int failures = 0;

  alu_issue_stage #(.WIDTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_ainv    (out_ainv),
    .out_binv    (out_binv),
    .out_sel     (out_sel),
    .out_cin     (out_cin),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  ctl;   // {ainv, binv, sel[1:0], cin, illegal}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_ctl(input logic [3:0] op);
    case (op)
      4'd0:    return 6'b000000;
      4'd1:    return 6'b000100;
      4'd2:    return 6'b001000;
      4'd3:    return 6'b011010;
      4'd4:    return 6'b011110;
      4'd5:    return 6'b110000;
      4'd6:    return 6'b110100;
      default: return 6'b000001;
    endcase
  endfunction

  function automatic logic [5:0] dut_ctl();
    return {out_ainv, out_binv, out_sel, out_cin, out_illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_a"}, out_a, 0);
    chk({tag, "_out_b"}, out_b, 0);
    chk({tag, "_ctl"}, dut_ctl(), 0);
  endtask

  logic [3:0]  q_op[$];
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  initial begin
    vecs[0]  = '{4'd3,  64'd5,                  64'd3,                  6'b011010};
    vecs[1]  = '{4'd0,  64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 6'b000000};
    vecs[2]  = '{4'd1,  64'h1234_5678_9ABC_DEF0, 64'h1,                  6'b000100};
    vecs[3]  = '{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                  6'b001000};
    vecs[4]  = '{4'd3,  64'h0,                  64'h1,                  6'b011010};
    vecs[5]  = '{4'd4,  64'h8000_0000_0000_0000, 64'h7,                  6'b011110};
    vecs[6]  = '{4'd5,  64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 6'b110000};
    vecs[7]  = '{4'd6,  64'hDEAD_BEEF,           64'hCAFE_F00D,           6'b110100};
    vecs[8]  = '{4'd9,  64'hFF,                 64'h0F,                 6'b000001};
    vecs[9]  = '{4'd2,  64'd1,                  64'd2,                  6'b001000};
    vecs[10] = '{4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  6'b000001};
    vecs[11] = '{4'd7,  64'h77,                 64'h88,                 6'b000001};
    vecs[12] = '{4'd0,  64'h3C,                 64'h0F,                 6'b000000};

    // Reset with in_valid asserted: nothing may be accepted.
    rst_n = 1'b0; in_valid = 1'b1; in_op = 4'd2; in_a = 64'h99; in_b = 64'h66; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_no_accept", out_valid, 0);

    // Back-to-back table stream with out_ready held high.
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      chk($sformatf("vec%0d_out_a", i), out_a, vecs[i].a);
      chk($sformatf("vec%0d_out_b", i), out_b, vecs[i].b);
      chk($sformatf("vec%0d_ctl", i), dut_ctl(), vecs[i].ctl);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_empty", out_valid, 0);

    // Back-pressure: fill main and skid, upstream holds a third op.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd2; in_a = 64'd1; in_b = 64'd0;
    tick();
    in_a = 64'd2;
    tick();
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_a_hold1", out_a, 1);
    in_a = 64'd3;
    tick();
    chk("bp_out_a_hold2", out_a, 1);
    chk("bp_in_ready_still_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_a2", out_a, 2);
    chk("bp_in_ready_back", in_ready, 1);
    tick();
    chk("bp_accept_a3", out_a, 3);
    chk("bp_accept_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);

    // Reset with both entries occupied.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd6; in_a = 64'h11; in_b = 64'h12;
    tick();
    in_a = 64'h22;
    tick();
    chk("mid_full_in_ready", in_ready, 0);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("mid_post_in_ready", in_ready, 1);
    chk("mid_post_out_valid", out_valid, 0);
    tick();
    chk("mid_no_ghost", out_valid, 0);

    // Random handshake against a queue model.
    begin
      int    accepted;
      int    cyc;
      logic  last_acc;
      accepted = 0; cyc = 0; last_acc = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      while (accepted < 10000 && cyc < 60000) begin
        if (!(in_valid && !last_acc)) begin
          in_valid = ($urandom_range(0, 9) < 7);
          in_op    = 4'($urandom_range(0, 15));
          in_a     = {$urandom, $urandom};
          in_b     = {$urandom, $urandom};
        end
        out_ready = ($urandom_range(0, 9) < 6);
        chk("rnd_in_ready", in_ready, (q_op.size() < 2));
        chk("rnd_out_valid", out_valid, (q_op.size() > 0));
        if (out_valid && out_ready && q_op.size() > 0) begin
          chk("rnd_out_a", out_a, q_a[0]);
          chk("rnd_out_b", out_b, q_b[0]);
          chk("rnd_ctl", dut_ctl(), exp_ctl(q_op[0]));
          void'(q_op.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front());
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
          q_op.push_back(in_op); q_a.push_back(in_a); q_b.push_back(in_b);
          accepted++;
        end
        tick();
        cyc++;
      end
      chk("rnd_all_accepted", accepted, 10000);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4 && q_op.size() > 0; k++) begin
        chk("rnd_tail_valid", out_valid, 1);
        chk("rnd_tail_a", out_a, q_a[0]);
        chk("rnd_tail_b", out_b, q_b[0]);
        chk("rnd_tail_ctl", dut_ctl(), exp_ctl(q_op[0]));
        void'(q_op.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front());
        tick();
      end
      chk("rnd_model_empty", q_op.size(), 0);
      chk("rnd_dut_empty", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the 64-bit ALU built from the 1-bit slice array.
- Accepts an abstract ALU operation plus two operands over a valid/ready handshake.
- Decodes the operation into the slice control set (A-invert, B-invert, 2-bit result select, carry-in) and presents operands and controls from registers.
- Contains a 2-entry skid buffer so back-pressure from the ALU/writeback side never drops or reorders operations.

Parameters:
- WIDTH, 64, operand width; equals the number of ALU slices.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept an operation this cycle
- in_op  in  4  operation code (alu_pkg encodings)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  issued operation valid
- out_ready  in  1  ALU side accepts the issued operation
- out_a  out  WIDTH  registered operand A
- out_b  out  WIDTH  registered operand B
- out_ainv  out  1  A-invert control to every slice
- out_binv  out  1  B-invert control to every slice
- out_sel  out  2  result select: 00 AND, 01 OR, 10 SUM, 11 LESS
- out_cin  out  1  carry-in to slice 0
- out_illegal  out  1  issued op code was not a legal encoding

Behaviour:
- Decode table (op → ainv, binv, sel, cin):
  - AND 0 → 0,0,00,0
  - OR 1 → 0,0,01,0
  - ADD 2 → 0,0,10,0
  - SUB 3 → 0,1,10,1
  - SLT 4 → 0,1,11,1
  - NOR 5 → 1,1,00,0
  - NAND 6 → 1,1,01,0
- Codes 7–15 are illegal:
  - Controls all 0 (AND).
  - Operands pass through unchanged.
  - out_illegal=1 for that entry only.
  - Illegal entries flow through the handshake like legal ones.
- Decode is done before capture; stored entry = {a, b, ainv, binv, sel, cin, illegal}.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_valid held while in_ready=0 is not a transfer; upstream holds its data.
- Storage:
  - Main register drives all out_* ports.
  - Skid register holds the second entry.
  - in_ready is a register equal to NOT skid_valid, updated each edge.
- Latency:
  - An accepted operation appears on out_* in the next cycle when main is empty or draining.
  - Sustained throughput is 1 op/cycle with out_ready=1.
- Capture and drain per clock edge:
  - Accept, with main empty or draining, skid empty: entry goes to main.
  - Accept while main full and not draining: entry goes to skid; in_ready drops next cycle.
  - Drain with skid full: skid moves to main; skid empties; in_ready rises next cycle.
  - Simultaneous accept and drain, skid empty: new entry replaces main; out_valid stays 1.
- Order is strictly FIFO; no entry is lost or duplicated.
- While out_valid=1 and out_ready=0, all out_* hold stable.
- Reset (rst_n sampled low at an edge):
  - out_valid=0, in_ready=0, skid empty.
  - out_a=0, out_b=0, out_ainv=0, out_binv=0, out_sel=00, out_cin=0, out_illegal=0.
  - in_ready returns to 1 at the first edge with rst_n=1.
  - Reset mid-operation discards both entries without a transfer.
  - An in_valid presented during reset is not accepted.

Decomposition:
- alu_pkg holds:
  - op-code localparams OP_AND..OP_NAND
  - result-select constants SEL_AND/SEL_OR/SEL_SUM/SEL_LESS
  - the packed issue-entry struct
  - the decode function
- One sub-module: alu_skid_buffer, parameterised on entry width; it owns the main/skid registers and the handshake.
- alu_issue_stage = decode + alu_skid_buffer.

Test Plan:
- Reset, then SUB a=5 b=3 with out_ready=1 → next cycle out_valid=1, out_ainv=0, out_binv=1, out_sel=10, out_cin=1, out_a=5, out_b=3.
- Stream AND, OR, ADD, SUB, SLT, NOR, NAND back-to-back with out_ready=1 → 7 consecutive outputs in order with the decode-table controls; in_ready stays 1 throughout.
- Hold out_ready=0, send ADD a=1, then ADD a=2 → in_ready=0 after the 2nd accept; out_a stays 1. Release out_ready → a=1 then a=2 drain on consecutive cycles; in_ready returns to 1.
- in_op=9, a=0xFF, b=0x0F → out_illegal=1, controls 0,0,00,0, operands unchanged; the following legal op shows out_illegal=0.
- Both entries full, assert rst_n=0 for one cycle → out_valid=0, in_ready=0, all outputs 0. Next cycle in_ready=1; pre-reset entries never appear.
- Random in_valid/out_ready toggling over 10k ops, scoreboard compare → output sequence equals input sequence, each entry decoded per table, no stall when skid empty.
